// File: rtl/life_row_streamer.sv
// Snapshot-and-stream reader for a GameOfLife board: captures the flat N*N cell
// vector on request and emits it one row per valid/ready beat, top row first.
module life_row_streamer #(
    parameter  int N  = 8,
    localparam int RW = (N > 1) ? $clog2(N) : 1,
    localparam int PW = $clog2(N * N + 1)
) (
    input  logic            clk,
    input  logic            nrst,
    input  logic [N*N-1:0]  cells,
    input  logic            capture,
    input  logic            out_ready,
    output logic            out_valid,
    output logic [N-1:0]    row_data,
    output logic [RW-1:0]   row_idx,
    output logic            sof,
    output logic            eof,
    output logic [PW-1:0]   out_pop,
    output logic            busy,
    output logic [7:0]      drop_count
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t          state_r;
    state_t          state_n;
    logic [N*N-1:0]  snap_r;
    logic [N*N-1:0]  snap_n;
    logic [RW-1:0]   row_idx_r;
    logic [RW-1:0]   row_idx_n;
    logic [PW-1:0]   acc_r;
    logic [PW-1:0]   acc_n;
    logic [7:0]      drop_r;
    logic [7:0]      drop_n;

    logic [N-1:0]    rows_s [N];
    logic [N-1:0]    row_sel_s;
    logic [PW-1:0]   row_pop_s;
    logic            last_s;
    logic            xfer_s;

    function automatic logic [PW-1:0] popcount(input logic [N-1:0] v);
        logic [PW-1:0] c;
        c = '0;
        for (int i = 0; i < N; i++) begin
            c = c + PW'(v[i]);
        end
        return c;
    endfunction

    // Row r occupies the r-th N-bit slice counted down from the vector MSB.
    for (genvar g = 0; g < N; g++) begin : g_rows
        assign rows_s[g] = snap_r[N*(N-g)-1 -: N];
    end

    // Select the snapshot row addressed by the current row index.
    always_comb begin
        row_sel_s = '0;
        for (int r = 0; r < N; r++) begin
            row_sel_s = (row_idx_r == RW'(r)) ? rows_s[r] : row_sel_s;
        end
    end

    assign row_pop_s = popcount(row_sel_s);
    assign last_s    = (row_idx_r == RW'(N - 1));
    assign xfer_s    = (state_r == SEND) && out_ready;

    // Next-state and datapath update for the IDLE/SEND controller.
    always_comb begin
        state_n   = state_r;
        snap_n    = snap_r;
        row_idx_n = row_idx_r;
        acc_n     = acc_r;
        drop_n    = drop_r;
        case (state_r)
            IDLE: begin
                if (capture) begin
                    snap_n    = cells;
                    row_idx_n = '0;
                    acc_n     = '0;
                    state_n   = SEND;
                end else begin
                    state_n   = IDLE;
                end
            end
            SEND: begin
                if (xfer_s && last_s) begin
                    // Final-row transfer: a capture here starts the next frame with no gap.
                    acc_n     = '0;
                    row_idx_n = '0;
                    if (capture) begin
                        snap_n  = cells;
                        state_n = SEND;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    if (xfer_s) begin
                        row_idx_n = row_idx_r + RW'(1);
                        acc_n     = acc_r + row_pop_s;
                    end else begin
                        row_idx_n = row_idx_r;
                    end
                    if (capture && (drop_r != 8'hFF)) begin
                        drop_n = drop_r + 8'd1;
                    end else begin
                        drop_n = drop_r;
                    end
                end
            end
            default: begin
                state_n   = IDLE;
                row_idx_n = '0;
                acc_n     = '0;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_r   <= IDLE;
            snap_r    <= '0;
            row_idx_r <= '0;
            acc_r     <= '0;
            drop_r    <= 8'd0;
        end else begin
            state_r   <= state_n;
            snap_r    <= snap_n;
            row_idx_r <= row_idx_n;
            acc_r     <= acc_n;
            drop_r    <= drop_n;
        end
    end

    // Beat outputs are gated by valid so an idle streamer presents all zeros.
    assign out_valid  = (state_r == SEND);
    assign busy       = out_valid;
    assign row_idx    = row_idx_r;
    assign row_data   = out_valid ? row_sel_s : '0;
    assign sof        = out_valid && (row_idx_r == '0);
    assign eof        = out_valid && last_s;
    assign out_pop    = out_valid ? (acc_r + row_pop_s) : '0;
    assign drop_count = drop_r;

endmodule

// File: tb/tb_life_row_streamer.sv
// Randomized scoreboard bench for life_row_streamer: a frame-level model queues
// expected beats on each accepted capture; a negedge monitor pops and compares.
module tb_life_row_streamer;

    localparam int N = 8;

    logic        clk = 1'b0;
    logic        nrst;
    logic        capture;
    logic        out_ready;
    logic [63:0] cells;
    logic        out_valid;
    logic [7:0]  row_data;
    logic [2:0]  row_idx;
    logic        sof;
    logic        eof;
    logic [6:0]  out_pop;
    logic        busy;
    logic [7:0]  drop_count;

    logic        capture1;
    logic        cells1;
    logic        out_valid1;
    logic        row_data1;
    logic        row_idx1;
    logic        sof1;
    logic        eof1;
    logic        out_pop1;
    logic        busy1;
    logic [7:0]  drop_count1;

    always #5 clk = ~clk;

    life_row_streamer #(.N(N)) dut (
        .clk(clk), .nrst(nrst), .cells(cells), .capture(capture), .out_ready(out_ready),
        .out_valid(out_valid), .row_data(row_data), .row_idx(row_idx), .sof(sof), .eof(eof),
        .out_pop(out_pop), .busy(busy), .drop_count(drop_count)
    );

    life_row_streamer #(.N(1)) dut1 (
        .clk(clk), .nrst(nrst), .cells(cells1), .capture(capture1), .out_ready(1'b1),
        .out_valid(out_valid1), .row_data(row_data1), .row_idx(row_idx1), .sof(sof1), .eof(eof1),
        .out_pop(out_pop1), .busy(busy1), .drop_count(drop_count1)
    );

    typedef struct {
        logic [7:0] data;
        logic [2:0] idx;
        logic       sof;
        logic       eof;
        logic [6:0] pop;
    } beat_t;

    beat_t       exp_q[$];
    beat_t       mb;
    int          n_vec = 0;
    int          n_fail = 0;
    int          exp_drop = 0;
    logic        mon_en = 1'b0;
    logic        pend_push = 1'b0;
    logic        pend_drop = 1'b0;
    logic        pend_rst = 1'b1;
    logic [63:0] pend_cells = 64'd0;

    localparam logic [63:0] GLIDER = 64'h4020E00000000000;
    localparam logic [63:0] ONES   = 64'hFFFFFFFFFFFFFFFF;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected frame: rows are successive bytes from the top of the board, pop is a running sum.
    task automatic push_frame(input logic [63:0] snap);
        int sum;
        sum = 0;
        for (int r = 0; r < 8; r++) begin
            beat_t b;
            logic [63:0] sh;
            sh     = snap >> (8 * (7 - r));
            b.data = sh[7:0];
            sum    = sum + $countones(b.data);
            b.idx  = 3'(r);
            b.sof  = (r == 0);
            b.eof  = (r == 7);
            b.pop  = 7'(sum);
            exp_q.push_back(b);
        end
    endtask

    // One clock of stimulus; the model commits the previous edge's outcome first.
    task automatic cycle(input logic c, input logic r, input logic [63:0] cv, input logic n);
        @(posedge clk);
        #1;
        if (pend_rst) begin
            exp_q.delete();
            exp_drop = 0;
            chk("rst_valid", out_valid, 0);
            chk("rst_busy", busy, 0);
            chk("rst_sof", sof, 0);
            chk("rst_eof", eof, 0);
            chk("rst_data", row_data, 0);
            chk("rst_idx", row_idx, 0);
            chk("rst_pop", out_pop, 0);
            chk("rst_drop", drop_count, 0);
            pend_rst = 1'b0;
            mon_en   = 1'b1;
        end
        if (pend_push) push_frame(pend_cells);
        if (pend_drop && exp_drop < 255) exp_drop++;
        pend_push = 1'b0;
        pend_drop = 1'b0;
        #1;
        capture   = c;
        out_ready = r;
        cells     = cv;
        nrst      = n;
        if (!n) begin
            pend_rst = 1'b1;
        end else if (c) begin
            if (exp_q.size() == 0 || (exp_q.size() == 1 && r)) begin
                pend_push  = 1'b1;
                pend_cells = cv;
            end else begin
                pend_drop = 1'b1;
            end
        end
    endtask

    // Monitor: compare the presented beat with the queue head, pop on transfer.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("valid", out_valid, exp_q.size() != 0);
            chk("busy", busy, exp_q.size() != 0);
            chk("drop", drop_count, exp_drop);
            if (exp_q.size() != 0) begin
                mb = exp_q[0];
                chk("row_data", row_data, mb.data);
                chk("row_idx", row_idx, mb.idx);
                chk("sof", sof, mb.sof);
                chk("eof", eof, mb.eof);
                chk("out_pop", out_pop, mb.pop);
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        nrst = 1'b0; capture = 1'b0; out_ready = 1'b1; cells = 64'd0;
        capture1 = 1'b0; cells1 = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        cycle(1'b0, 1'b1, 64'd0, 1'b1);

        // Glider, then cells go all ones right after capture; a second capture streams ones.
        cycle(1'b1, 1'b1, GLIDER, 1'b1);
        for (int i = 0; i < 9; i++) cycle(1'b0, 1'b1, ONES, 1'b1);
        cycle(1'b1, 1'b1, ONES, 1'b1);
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 64'd0, 1'b1);

        // Backpressure with ready pattern 1,0,0 repeating.
        cycle(1'b1, 1'b1, GLIDER ^ 64'h0123456789ABCDEF, 1'b1);
        for (int i = 0; i < 30; i++) cycle(1'b0, (i % 3) == 0, 64'd0, 1'b1);

        // Overrun: three held capture cycles mid-frame.
        cycle(1'b0, 1'b1, 64'd0, 1'b0);
        cycle(1'b1, 1'b1, 64'hA5A5A5A5A5A5A5A5, 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 64'd0, 1'b1);
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 64'd0, 1'b1);
        chk("drop_three", drop_count, 8'd3);

        // Back-to-back: capture lands on the final-row transfer.
        cycle(1'b1, 1'b1, 64'h00FF00FF00FF00FF, 1'b1);
        for (int i = 0; i < 7; i++) cycle(1'b0, 1'b1, 64'd0, 1'b1);
        cycle(1'b1, 1'b1, 64'h8040201008040201, 1'b1);
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 64'd0, 1'b1);
        chk("drop_b2b", drop_count, 8'd3);

        // Saturation: 300 captures while stalled.
        cycle(1'b1, 1'b1, 64'h0F0F0F0F0F0F0F0F, 1'b1);
        for (int i = 0; i < 300; i++) cycle(1'b1, 1'b0, 64'd0, 1'b1);
        for (int i = 0; i < 12; i++) cycle(1'b0, 1'b1, 64'd0, 1'b1);
        chk("drop_sat", drop_count, 8'd255);

        // Reset during beat 3, then a fresh frame.
        cycle(1'b1, 1'b1, GLIDER, 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 64'd0, 1'b1);
        cycle(1'b1, 1'b1, ONES, 1'b0);
        cycle(1'b1, 1'b1, 64'h123456789ABCDEF0, 1'b1);
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 64'd0, 1'b1);

        // Randomized traffic.
        for (int i = 0; i < 2500; i++) begin
            cycle($urandom_range(0, 5) == 0, $urandom_range(0, 3) != 0,
                  {$urandom(), $urandom()}, $urandom_range(0, 499) != 0);
        end
        for (int i = 0; i < 40; i++) cycle(1'b0, 1'b1, 64'd0, 1'b1);
        chk("drained", exp_q.size(), 0);

        // Single-cell board.
        @(posedge clk);
        #2;
        capture1 = 1'b1;
        cells1   = 1'b1;
        @(posedge clk);
        #1;
        capture1 = 1'b0;
        chk("n1_valid", out_valid1, 1);
        chk("n1_sof", sof1, 1);
        chk("n1_eof", eof1, 1);
        chk("n1_pop", out_pop1, 1);
        chk("n1_idx", row_idx1, 0);
        chk("n1_data", row_data1, 1);
        @(posedge clk);
        #1;
        chk("n1_done", out_valid1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
